// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and bit-timing load constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  function automatic int bit_load(input int fclk, input int baud);
    return fclk / baud - 1;
  endfunction

  function automatic int half_load(input int fclk, input int baud);
    return (fclk / baud) / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency, no backpressure.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN); byte/error pulses one cycle after the stop sample.
// No backpressure: rx_valid is a strobe, the consumer must take rx_data in that cycle or read the held value later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FCLK = 50000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       idle
);

  localparam int BIT_LOAD  = bit_load(FCLK, BAUD);
  localparam int HALF_LOAD = half_load(FCLK, BAUD);
  localparam int CW        = $clog2(BIT_LOAD + 1);

  logic rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic           par_bad_q, par_bad_d;
  logic           parity_err_q, parity_err_d;
`endif
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = CW'(HALF_LOAD);
          state_d = START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            cnt_d     = CW'(BIT_LOAD);
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CW'(BIT_LOAD);
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: the received bit must equal the XOR of the data bits.
        if (cnt_zero) begin
          par_bad_d = rx_s ^ (^shift_q);
          cnt_d     = CW'(BIT_LOAD);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign idle      = (state_q == IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
